pm_boot_loader: RTL and testbench

- Byte-stream program loader that sits upstream of program memory and the core's stall input.
- Holds the core stalled from reset and accepts a length-prefixed byte stream over a valid/ready handshake.
- Packs the bytes into PMD_SIZE-bit words and writes them sequentially into program memory.
- Releases the core stall when the load completes successfully.

---
 rtl/pm_boot_loader.sv | 248 ++++++++++++++++++++++++
 tb/tb_pm_boot_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pm_boot_loader.sv
// Byte-stream program loader: holds the core stalled, packs a length-prefixed byte stream
// into PM words and releases the stall on success. Optional checksum: PM_BOOT_CHECKSUM_EN.
module pm_boot_loader #(
    parameter int PMA_SIZE  = 16,
    parameter int PMD_SIZE  = 32,
    parameter int LOAD_BASE = 0,
    parameter int PM_DEPTH  = 65536
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                boot_start,
    input  logic [7:0]          rx_dt,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                pm_wr_en,
    output logic [PMA_SIZE-1:0] pm_wr_add,
    output logic [PMD_SIZE-1:0] pm_wr_dt,
    output logic                core_stallb,
    output logic                boot_busy,
    output logic                boot_done,
    output logic                boot_err,
    output logic [15:0]         word_cnt
);

    localparam int                  NB        = PMD_SIZE / 8;
    localparam logic [3:0]          LAST_IDX  = 4'(NB - 1);
    localparam logic [PMA_SIZE-1:0] BASE_ADDR = PMA_SIZE'(LOAD_BASE);
    localparam logic [PMA_SIZE-1:0] ADDR_ONE  = PMA_SIZE'(1);
    localparam logic [31:0]         DEPTH_U   = 32'(PM_DEPTH);

`ifdef PM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;
    localparam state_t S_FINAL = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [3:0]            idx_q, idx_d;
    logic [PMD_SIZE-1:0]   asm_q, asm_d;
    logic [PMA_SIZE-1:0]   addr_q, addr_d;
    logic [15:0]           cnt_q, cnt_d;
`ifdef PM_BOOT_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
`endif
    logic                  rdy_q, rdy_d;
    logic                  wr_en_q, wr_en_d;
    logic                  stallb_q, stallb_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  xfer_s;

    // rdy_q always mirrors the current state, so it qualifies the handshake directly
    assign xfer_s = rx_valid & rdy_q;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef PM_BOOT_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (boot_start) begin
                    state_d = S_LEN_HI;
                    cnt_d   = 16'd0;
                    addr_d  = BASE_ADDR;
                    idx_d   = 4'd0;
`ifdef PM_BOOT_CHECKSUM_EN
                    xor_d   = 8'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    len_d   = {rx_dt, len_q[7:0]};
                    state_d = S_LEN_LO;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (xfer_s) begin
                    len_d = {len_q[15:8], rx_dt};
                    if ({16'd0, len_d} > DEPTH_U) begin
                        state_d = S_ERROR;
                    end else if (len_d == 16'd0) begin
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    // earlier bytes move toward the MSB, so the first byte ends up on top
                    asm_d = (asm_q << 4'd8) | PMD_SIZE'(rx_dt);
`ifdef PM_BOOT_CHECKSUM_EN
                    xor_d = xor_q ^ rx_dt;
`endif
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = S_WRITE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                cnt_d  = cnt_q + 16'd1;
                addr_d = addr_q + ADDR_ONE;
                if (cnt_d == len_q) begin
                    state_d = S_FINAL;
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef PM_BOOT_CHECKSUM_EN
            S_CHK: begin
                if (xfer_s) begin
                    state_d = (rx_dt == xor_q) ? S_DONE : S_ERROR;
                end else begin
                    state_d = S_CHK;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flags are decoded from the next state so they register alongside it
    always_comb begin
        rdy_d    = 1'b0;
        wr_en_d  = 1'b0;
        stallb_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_d)
            S_LEN_HI, S_LEN_LO, S_DATA: begin
                rdy_d  = 1'b1;
                busy_d = 1'b1;
            end
`ifdef PM_BOOT_CHECKSUM_EN
            S_CHK: begin
                rdy_d  = 1'b1;
                busy_d = 1'b1;
            end
`endif
            S_WRITE: begin
                wr_en_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_DONE: begin
                done_d   = 1'b1;
                stallb_d = 1'b1;
            end
            S_ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                rdy_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            len_q    <= 16'd0;
            idx_q    <= 4'd0;
            asm_q    <= '0;
            addr_q   <= BASE_ADDR;
            cnt_q    <= 16'd0;
`ifdef PM_BOOT_CHECKSUM_EN
            xor_q    <= 8'd0;
`endif
            rdy_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            stallb_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
`ifdef PM_BOOT_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
            rdy_q    <= rdy_d;
            wr_en_q  <= wr_en_d;
            stallb_q <= stallb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rx_ready    = rdy_q;
    assign pm_wr_en    = wr_en_q;
    assign pm_wr_add   = addr_q;
    assign pm_wr_dt    = asm_q;
    assign core_stallb = stallb_q;
    assign boot_busy   = busy_q;
    assign boot_done   = done_q;
    assign boot_err    = err_q;
    assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_pm_boot_loader.sv
// Directed table-driven bench for pm_boot_loader (PMD_SIZE=32, PM_DEPTH=4).
module tb_pm_boot_loader;

    logic        clk = 1'b0;
    logic        reset, boot_start, rx_valid;
    logic [7:0]  rx_dt;
    logic        rx_ready, pm_wr_en, core_stallb, boot_busy, boot_done, boot_err;
    logic [15:0] pm_wr_add, word_cnt;
    logic [31:0] pm_wr_dt;

    always #5 clk = ~clk;

    pm_boot_loader #(.PMA_SIZE(16), .PMD_SIZE(32), .LOAD_BASE(0), .PM_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .boot_start(boot_start), .rx_dt(rx_dt), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .pm_wr_en(pm_wr_en), .pm_wr_add(pm_wr_add), .pm_wr_dt(pm_wr_dt),
        .core_stallb(core_stallb), .boot_busy(boot_busy), .boot_done(boot_done),
        .boot_err(boot_err), .word_cnt(word_cnt)
    );

    typedef struct {
        int           nb;
        logic [255:0] b;      // stream bytes, first byte in the most significant used position
        logic [7:0]   ck;
        bit           has_ck;
        bit           gap;
        int           exp_nw;
        logic [3:0][31:0] w;
        bit           done;
        bit           err;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // write monitor: records every PM write and flags protocol slips
    int          nw = 0, bad_rdy = 0, bad_pulse = 0;
    logic        prev_en = 1'b0;
    logic [15:0] wa [0:63];
    logic [31:0] wd [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pm_wr_en) begin
            wa[6'(nw)] <= pm_wr_add;
            wd[6'(nw)] <= pm_wr_dt;
            nw <= nw + 1;
            if (rx_ready) bad_rdy <= bad_rdy + 1;
            if (prev_en) bad_pulse <= bad_pulse + 1;
        end
        prev_en <= pm_wr_en;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // entered and left on a negedge; the byte transfers on the posedge in between
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int tmo;
        int g;
        g = gap ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_dt = b;
        tmo = 0;
        while (!rx_ready && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        checks++;
        if (tmo >= 50) begin
            failures++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base, br, bp, t0, tmo, lat;
        base = nw; br = bad_rdy; bp = bad_pulse;
        @(negedge clk);
        boot_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        boot_start = 1'b0;
        chk({tag, "_start_stallb"}, 64'(core_stallb), 64'd0);
        chk({tag, "_start_busy"}, 64'(boot_busy), 64'd1);
        for (int i = 0; i < v.nb; i++) send_byte(v.b[8*(v.nb-1-i) +: 8], v.gap);
        lat = 3 + v.exp_nw * 5;
`ifdef PM_BOOT_CHECKSUM_EN
        if (v.has_ck) send_byte(v.ck, v.gap);
        lat = lat + 1;
`endif
        tmo = 0;
        while (!(boot_done || boot_err) && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        if (!v.gap && v.done) chk({tag, "_latency"}, 64'(cyc - t0), 64'(lat));
        chk({tag, "_nwrites"}, 64'(nw - base), 64'(v.exp_nw));
        for (int k = 0; k < v.exp_nw; k++) begin
            chk($sformatf("%s_addr%0d", tag, k), 64'(wa[6'(base + k)]), 64'(k));
            chk($sformatf("%s_data%0d", tag, k), 64'(wd[6'(base + k)]), 64'(v.w[k]));
        end
        chk({tag, "_done"}, 64'(boot_done), 64'(v.done));
        chk({tag, "_err"}, 64'(boot_err), 64'(v.err));
        chk({tag, "_stallb"}, 64'(core_stallb), 64'(v.done));
        chk({tag, "_busy"}, 64'(boot_busy), 64'd0);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(v.exp_nw));
        chk({tag, "_rdy_in_write"}, 64'(bad_rdy - br), 64'd0);
        chk({tag, "_wr_pulse"}, 64'(bad_pulse - bp), 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_wr_en"}, 64'(pm_wr_en), 64'd0);
        chk({tag, "_wr_add"}, 64'(pm_wr_add), 64'd0);
        chk({tag, "_wr_dt"}, 64'(pm_wr_dt), 64'd0);
        chk({tag, "_stallb"}, 64'(core_stallb), 64'd0);
        chk({tag, "_busy"}, 64'(boot_busy), 64'd0);
        chk({tag, "_done"}, 64'(boot_done), 64'd0);
        chk({tag, "_err"}, 64'(boot_err), 64'd0);
        chk({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
    endtask

    vec_t vecs [0:7];
    int   nv;
    vec_t rv;
    int   pre;

    initial begin
        // stimulus table
        vecs[0] = '{nb: 10, b: 256'({8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78}),
                    ck: 8'h2A, has_ck: 1'b1, gap: 1'b0, exp_nw: 2,
                    w: {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF}, done: 1'b1, err: 1'b0};
        vecs[1] = vecs[0];
        vecs[1].gap = 1'b1;
        vecs[2] = '{nb: 2, b: 256'({8'h00, 8'h00}), ck: 8'h00, has_ck: 1'b1, gap: 1'b0, exp_nw: 0,
                    w: '0, done: 1'b1, err: 1'b0};
        vecs[3] = '{nb: 2, b: 256'({8'h00, 8'h05}), ck: 8'h00, has_ck: 1'b0, gap: 1'b0, exp_nw: 0,
                    w: '0, done: 1'b0, err: 1'b1};
        vecs[4] = '{nb: 18, b: 256'({8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                     8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10}),
                    ck: 8'h10, has_ck: 1'b1, gap: 1'b0, exp_nw: 4,
                    w: {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304}, done: 1'b1, err: 1'b0};
        vecs[5] = '{nb: 2, b: 256'({8'h01, 8'h00}), ck: 8'h00, has_ck: 1'b0, gap: 1'b0, exp_nw: 0,
                    w: '0, done: 1'b0, err: 1'b1};
        vecs[6] = '{nb: 6, b: 256'({8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}), ck: 8'h44, has_ck: 1'b1,
                    gap: 1'b0, exp_nw: 1, w: {32'h0, 32'h0, 32'h0, 32'h11223344}, done: 1'b1, err: 1'b0};
        nv = 7;
`ifdef PM_BOOT_CHECKSUM_EN
        vecs[7] = vecs[6];
        vecs[7].ck = 8'h45;
        vecs[7].done = 1'b0;
        vecs[7].err = 1'b1;
        nv = 8;
`endif

        reset = 1'b0; boot_start = 1'b0; rx_valid = 1'b0; rx_dt = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk_reset_state("reset");

        for (int i = 0; i < nv; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // reset after three data bytes, then a fresh one-word load
        pre = nw;
        @(negedge clk);
        boot_start = 1'b1;
        @(negedge clk);
        boot_start = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk_reset_state("midrst");
        chk("midrst_nwrites", 64'(nw - pre), 64'd0);
        rv = '{nb: 6, b: 256'({8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE}), ck: 8'h30, has_ck: 1'b1,
               gap: 1'b0, exp_nw: 1, w: {32'h0, 32'h0, 32'h0, 32'hCAFEBABE}, done: 1'b1, err: 1'b0};
        run_vec(rv, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
